// File: rtl/uart8_host_pkg.sv
// Shared types and default sizing for the uart8_host block.
package uart8_host_pkg;

    localparam int unsigned FifoDepthDefault  = 8;
    localparam int unsigned SyncStagesDefault = 2;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStart,
        StWait
    } tx_state_e;

endpackage

// File: rtl/uart8_host_if.sv
// Host-side bus of uart8_host: TX push, RX pop, levels and sticky error flags.
interface uart8_host_if
    import uart8_host_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FifoDepthDefault
) ();

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          rx_overflow;
    logic          rx_frame_err;
    logic          clr_err;

    modport master (
        output wr_data, wr_valid, rd_ready, clr_err,
        input  wr_ready, rd_data, rd_valid, tx_level, rx_level, rx_overflow, rx_frame_err
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready, clr_err,
        output wr_ready, rd_data, rd_valid, tx_level, rx_level, rx_overflow, rx_frame_err
    );

endinterface

// File: rtl/uart8_host_fifo.sv
// Synchronous FIFO with wrapping pointers and a separately tracked level.
module uart8_host_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

    // Next-state pointers and occupancy.
    always_comb begin
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage array; contents are meaningless while empty so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart8_host.sv
// Host adapter between a byte-stream bus and a simple UART transmitter/receiver pair.
module uart8_host
    import uart8_host_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = FifoDepthDefault,
    parameter int unsigned SYNC_STAGES = SyncStagesDefault,
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst,
    uart8_host_if.slave host,
    output logic [7:0] uart_tx_data,
    output logic       uart_tx_start,
    output logic       uart_tx_en,
    input  logic       uart_tx_busy,
    input  logic       uart_tx_done,
    output logic       uart_rx_en,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_rx_done,
    input  logic       uart_rx_err
);

    // Synchronizer bit order: {rx_err, rx_done, tx_done, tx_busy}.
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0] sync_s;
    logic [2:0] prev_q;
    logic       busy_s, busy_fall, done_rise, rx_rise, rx_err_s;

    tx_state_e  state_q;
    logic [7:0] tx_data_q;
    logic       tx_start_q;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_rdata;
    logic [LW-1:0] tx_level;

    logic       rx_push, rx_pop, rx_full, rx_empty, rx_ok;
    logic [7:0] rx_rdata;
    logic [LW-1:0] rx_level;
    logic       ovf_q, frame_q, ovf_set, frame_set;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= {uart_rx_err, uart_rx_done, uart_tx_done, uart_tx_busy};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_s[2:0];
        end
    end

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign busy_s    = sync_s[0];
    assign busy_fall = prev_q[0] && !sync_s[0];
    assign done_rise = sync_s[1] && !prev_q[1];
    assign rx_rise   = sync_s[2] && !prev_q[2];
    assign rx_err_s  = sync_s[3];

    assign uart_tx_en = !rst;
    assign uart_rx_en = !rst;

    // TX path.
    assign host.wr_ready = !rst && !tx_full;
    assign tx_push       = host.wr_valid && host.wr_ready;
    assign tx_pop        = (state_q == StLoad);
    assign host.tx_level = tx_level;
    assign uart_tx_data  = tx_data_q;
    assign uart_tx_start = tx_start_q;

    uart8_host_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .wdata_i (host.wr_data),
        .pop_i   (tx_pop),
        .rdata_o (tx_rdata),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    // TX sequencer: fetch a byte, hold start until the transmitter reports busy, await completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!tx_empty) state_q <= StLoad;
                end
                StLoad: begin
                    tx_data_q  <= tx_rdata;
                    tx_start_q <= 1'b1;
                    state_q    <= StStart;
                end
                StStart: begin
                    if (busy_s) begin
                        tx_start_q <= 1'b0;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (busy_fall || done_rise) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RX path: capture on a synchronized done edge; errored frames never reach the FIFO.
    assign rx_ok         = rx_rise && !rx_err_s;
    assign rx_push       = rx_ok;
    assign rx_pop        = host.rd_valid && host.rd_ready;
    assign ovf_set       = rx_ok && rx_full && !rx_pop;
    assign frame_set     = rx_rise && rx_err_s;
    assign host.rd_valid = !rx_empty;
    assign host.rd_data  = rx_rdata;
    assign host.rx_level = rx_level;

    uart8_host_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .wdata_i (uart_rx_data),
        .pop_i   (rx_pop),
        .rdata_o (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    // Sticky error flags; a new event in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            if (ovf_set) ovf_q <= 1'b1;
            else if (host.clr_err) ovf_q <= 1'b0;
            if (frame_set) frame_q <= 1'b1;
            else if (host.clr_err) frame_q <= 1'b0;
        end
    end

    assign host.rx_overflow  = ovf_q;
    assign host.rx_frame_err = frame_q;

endmodule

// File: tb/tb_uart8_host.sv
// Scoreboard bench for uart8_host: stimulus queues expected bytes, monitors pop and compare.
module tb_uart8_host;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] uart_tx_data;
    logic       uart_tx_start, uart_tx_en, uart_tx_busy, uart_tx_done;
    logic       uart_rx_en;
    logic [7:0] uart_rx_data;
    logic       uart_rx_done, uart_rx_err;

    int n_vec = 0;
    int n_err = 0;
    int n_starts = 0;
    bit tx_act = 1'b0;
    bit tx_stall = 1'b0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    uart8_host_if #(.FIFO_DEPTH(8)) bus ();

    uart8_host #(
        .FIFO_DEPTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host          (bus),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_start (uart_tx_start),
        .uart_tx_en    (uart_tx_en),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_done  (uart_tx_done),
        .uart_rx_en    (uart_rx_en),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_done  (uart_rx_done),
        .uart_rx_err   (uart_rx_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy rises 3 cycles after start, stays 40 cycles (longer while stalled).
    initial begin : tx_model
        int cnt;
        cnt = 0;
        uart_tx_busy = 1'b0;
        uart_tx_done = 1'b0;
        forever begin
            tick();
            uart_tx_done = 1'b0;
            if (rst) begin
                tx_act = 1'b0;
                cnt = 0;
                uart_tx_busy = 1'b0;
            end else if (!tx_act) begin
                if (uart_tx_start) begin
                    tx_act = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt == 3) uart_tx_busy = 1'b1;
                if (cnt >= 43 && !tx_stall) begin
                    uart_tx_busy = 1'b0;
                    uart_tx_done = 1'b1;
                    tx_act = 1'b0;
                end
            end
        end
    end

    // TX monitor: every start rising edge must carry the next queued byte.
    initial begin : tx_mon
        logic prev;
        logic [7:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_tx_start === 1'b1 && prev !== 1'b1) begin
                n_starts++;
                if (tx_exp.size() == 0) begin
                    chk("tx_unexpected_start", 32'(uart_tx_data), 32'hFFFF_FFFF);
                end else begin
                    e = tx_exp.pop_front();
                    chk("tx_byte", 32'(uart_tx_data), 32'(e));
                end
            end
            prev = uart_tx_start;
        end
    end

    // RX monitor: every pop must return the next queued byte.
    initial begin : rx_mon
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
                if (rx_exp.size() == 0) begin
                    chk("rx_unexpected_pop", 32'(bus.rd_data), 32'hFFFF_FFFF);
                end else begin
                    e = rx_exp.pop_front();
                    chk("rx_byte", 32'(bus.rd_data), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [7:0] b, input bit expect_tx, output logic acc);
        bus.wr_data  = b;
        bus.wr_valid = 1'b1;
        acc = bus.wr_ready;
        tick();
        bus.wr_valid = 1'b0;
        if (acc && expect_tx) tx_exp.push_back(b);
    endtask

    // Done pulse spanning two cycles; capture lands on the third edge after it rises.
    task automatic rx_pulse(input logic [7:0] d, input logic err, input logic clr_cap,
                            input logic rdy_cap, output logic vld4);
        uart_rx_data = d;
        uart_rx_err  = err;
        uart_rx_done = 1'b1;
        tick();
        tick();
        uart_rx_done = 1'b0;
        bus.clr_err  = clr_cap;
        if (rdy_cap) bus.rd_ready = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        if (rdy_cap) bus.rd_ready = 1'b0;
        tick();
        vld4 = bus.rd_valid;
        tick();
    endtask

    task automatic wait_tx_idle(input int budget);
        int k;
        k = 0;
        while ((tx_exp.size() != 0 || tx_act || bus.tx_level != 0) && k < budget) begin
            tick();
            k++;
        end
        repeat (6) tick();
        chk("tx_drain_pending", 32'(tx_exp.size()), 32'd0);
    endtask

    task automatic rx_drain(input int budget);
        int k;
        k = 0;
        bus.rd_ready = 1'b1;
        while (bus.rx_level != 0 && k < budget) begin
            tick();
            k++;
        end
        bus.rd_ready = 1'b0;
        tick();
        chk("rx_drain_pending", 32'(rx_exp.size()), 32'd0);
        chk("rx_drain_level", 32'(bus.rx_level), 32'd0);
    endtask

    task automatic clear_err();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
    endtask

    initial begin : stim
        logic acc;
        logic vld4;
        logic [8:0] acc_mask;
        int starts0;
        int k;

        rst          = 1'b1;
        bus.wr_data  = '0;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        bus.clr_err  = 1'b0;
        uart_rx_data = '0;
        uart_rx_done = 1'b0;
        uart_rx_err  = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_en", 32'({uart_tx_en, uart_rx_en}), 32'd0);
        chk("rst_start_data", 32'({uart_tx_start, uart_tx_data}), 32'd0);
        chk("rst_levels", 32'({bus.tx_level, bus.rx_level}), 32'd0);
        chk("rst_flags", 32'({bus.rx_overflow, bus.rx_frame_err, bus.rd_valid}), 32'd0);
        rst = 1'b0;
        tick();
        chk("run_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("run_en", 32'({uart_tx_en, uart_rx_en}), 32'b11);

        // Single byte into an idle block.
        push(8'hA5, 1'b1, acc);
        chk("a5_accepted", 32'(acc), 32'd1);
        wait_tx_idle(300);
        chk("a5_start_count", 32'(n_starts), 32'd1);
        chk("a5_data_held", 32'(uart_tx_data), 32'hA5);
        chk("a5_tx_level", 32'(bus.tx_level), 32'd0);

        // Start must rise on exactly the second edge after the push edge.
        push(8'h3E, 1'b1, acc);
        chk("lat_start_edge0", 32'(uart_tx_start), 32'd0);
        tick();
        chk("lat_start_edge1", 32'(uart_tx_start), 32'd0);
        tick();
        chk("lat_start_edge2", 32'(uart_tx_start), 32'd1);
        chk("lat_data", 32'(uart_tx_data), 32'h3E);
        wait_tx_idle(300);

        // Fill with the transmitter stalled; the LOAD pop makes room for the ninth byte.
        starts0  = n_starts;
        tx_stall = 1'b1;
        acc_mask = '0;
        for (int i = 0; i < 9; i++) begin
            push(8'(i + 1), 1'b1, acc);
            acc_mask[i] = acc;
        end
        chk("fill_accept_mask", 32'(acc_mask), 32'h1FF);
        chk("fill_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("fill_tx_level", 32'(bus.tx_level), 32'd8);
        push(8'h0A, 1'b1, acc);
        chk("fill_reject_10th", 32'(acc), 32'd0);
        tx_stall = 1'b0;
        wait_tx_idle(1500);
        chk("fill_start_count", 32'(n_starts - starts0), 32'd9);

        // Nine receptions with no reader: eight stored, then overflow.
        for (int i = 0; i < 9; i++) begin
            rx_pulse(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, vld4);
            if (i < 8) rx_exp.push_back(8'h10 + 8'(i));
            if (i == 0) chk("rx_latency_valid", 32'(vld4), 32'd1);
        end
        chk("ovf_rx_level", 32'(bus.rx_level), 32'd8);
        chk("ovf_flag", 32'({bus.rx_overflow, bus.rx_frame_err}), 32'b10);
        clear_err();
        chk("ovf_cleared", 32'(bus.rx_overflow), 32'd0);
        rx_drain(50);

        // Framing error drops the byte.
        rx_pulse(8'h55, 1'b1, 1'b0, 1'b0, vld4);
        chk("ferr_rx_level", 32'(bus.rx_level), 32'd0);
        chk("ferr_flag", 32'(bus.rx_frame_err), 32'd1);
        chk("ferr_no_valid", 32'(bus.rd_valid), 32'd0);
        clear_err();
        chk("ferr_cleared", 32'(bus.rx_frame_err), 32'd0);
        // Clear asserted in the very cycle of a new error: the set wins.
        rx_pulse(8'h66, 1'b1, 1'b1, 1'b0, vld4);
        chk("ferr_set_beats_clr", 32'(bus.rx_frame_err), 32'd1);

        // Full FIFO with a pop in the capture cycle accepts the byte.
        for (int i = 0; i < 8; i++) begin
            rx_pulse(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0, vld4);
            rx_exp.push_back(8'h20 + 8'(i));
        end
        chk("full_rx_level", 32'(bus.rx_level), 32'd8);
        rx_pulse(8'h3C, 1'b0, 1'b0, 1'b1, vld4);
        rx_exp.push_back(8'h3C);
        chk("full_pop_level", 32'(bus.rx_level), 32'd8);
        chk("full_pop_no_ovf", 32'(bus.rx_overflow), 32'd0);
        rx_drain(50);

        // Reset while waiting on the transmitter abandons everything.
        push(8'h77, 1'b1, acc);
        k = 0;
        while (uart_tx_busy !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk("wait_busy_seen", 32'(uart_tx_busy), 32'd1);
        repeat (5) tick();
        push(8'h78, 1'b0, acc);
        push(8'h79, 1'b0, acc);
        chk("wait_tx_level", 32'(bus.tx_level), 32'd2);
        starts0 = n_starts;
        rst = 1'b1;
        tick();
        chk("mid_rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("mid_rst_en", 32'({uart_tx_en, uart_rx_en}), 32'd0);
        chk("mid_rst_start_data", 32'({uart_tx_start, uart_tx_data}), 32'd0);
        chk("mid_rst_levels", 32'({bus.tx_level, bus.rx_level}), 32'd0);
        chk("mid_rst_flags", 32'({bus.rx_overflow, bus.rx_frame_err}), 32'd0);
        tick();
        rst = 1'b0;
        repeat (60) tick();
        chk("post_rst_no_start", 32'(n_starts - starts0), 32'd0);
        chk("post_rst_tx_level", 32'(bus.tx_level), 32'd0);
        chk("post_rst_tx_queue", 32'(tx_exp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart8_host.md
UART8_HOST -- requirements
Module: uart8_host

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, meaning: entries per TX and RX FIFO (power of 2, >=2).
REQ-002 Parameter SYNC_STAGES, default 2, meaning: flop stages on each UART-side input.
REQ-003 Port clk, input, 1, meaning: the block's only clock; all logic on its rising edge.
REQ-004 Port rst, input, 1, meaning: synchronous, active-high reset.
REQ-005 Port wr_data, input, 8, meaning: byte to transmit.
REQ-006 Port wr_valid / wr_ready, input / output, 1 each, meaning: TX push handshake.
REQ-007 Port rd_data, output, 8, meaning: oldest received byte.
REQ-008 Port rd_valid / rd_ready, output / input, 1 each, meaning: RX pop handshake.
REQ-009 Ports tx_level / rx_level, output, $clog2(FIFO_DEPTH)+1 each, meaning: FIFO occupancy.
REQ-010 Ports rx_overflow / rx_frame_err, output, 1 each, meaning: sticky error flags.
REQ-011 Port clr_err, input, 1, meaning: clear both sticky flags.
REQ-012 Ports uart_tx_data (output, 8), uart_tx_start (output, 1), uart_tx_en (output, 1), meaning: drive transmitter.
REQ-013 Ports uart_tx_busy, uart_tx_done (input, 1 each), meaning: transmitter status.
REQ-014 Ports uart_rx_en (output, 1), uart_rx_data (input, 8), uart_rx_done, uart_rx_err (input, 1 each), meaning: receiver side.

Function
REQ-015 uart_tx_busy, uart_tx_done, uart_rx_done and uart_rx_err SHALL pass through SYNC_STAGES flops before use; uart_rx_data SHALL be sampled only on a synchronized uart_rx_done rising edge.
REQ-016 A push SHALL occur when wr_valid and wr_ready are both high; wr_ready SHALL equal TX FIFO not full.
REQ-017 TX FSM states SHALL be IDLE, LOAD, START, WAIT.
REQ-018 IDLE -> LOAD when TX FIFO is non-empty; LOAD pops one byte into uart_tx_data, which SHALL then be held until the FSM returns to IDLE.
REQ-019 LOAD -> START; START SHALL hold uart_tx_start high until synchronized busy is seen high, then -> WAIT with uart_tx_start low.
REQ-020 WAIT -> IDLE on a synchronized busy falling edge or a synchronized done rising edge, whichever comes first.
REQ-021 With the FSM in IDLE and the FIFO empty, uart_tx_start SHALL rise on the 2nd clk edge after the push edge.
REQ-022 uart_tx_en and uart_rx_en SHALL be 1 whenever rst is low.
REQ-023 On a synchronized rx_done rising edge with synchronized rx_err low: the byte SHALL be written to the RX FIFO, with rd_valid high no later than SYNC_STAGES+2 cycles after uart_rx_done rises.
REQ-024 Same edge with rx_err high: the byte SHALL be dropped and rx_frame_err set.
REQ-025 RX FIFO full at capture with no pop in that cycle: the byte SHALL be dropped and rx_overflow set; full with a simultaneous pop: the byte SHALL be accepted and rx_level unchanged.
REQ-026 rd_valid SHALL equal RX FIFO not empty, and rd_data SHALL be valid whenever rd_valid is high; a pop SHALL occur on rd_valid and rd_ready.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with level tracked separately (full = level==FIFO_DEPTH).
REQ-028 clr_err SHALL clear both flags on the next edge; a same-cycle set SHALL win over clr_err.

Reset
REQ-029 rst high SHALL drive, on the next clk edge: FSM IDLE; both FIFOs empty; all sync flops 0; uart_tx_start, uart_tx_en, uart_rx_en, flags and uart_tx_data all 0; wr_ready 0 during reset, 1 after.
REQ-030 Reset mid-frame SHALL abandon the byte in flight and all FIFO contents, with no uart_tx_start pulse generated by the reset itself.

Structure
REQ-031 Package uart8_host_pkg SHALL hold the TX FSM state enum and the default FIFO_DEPTH/SYNC_STAGES constants.
REQ-032 One sub-module, uart8_host_fifo (synchronous FIFO with level output), SHALL be instantiated twice (TX and RX).

Verification
REQ-033 Push 0xA5 into idle block, model the transmitter (busy 3 cycles after start, held 40 cycles) -> one start pulse, uart_tx_data=0xA5, tx_level returns to 0, FSM in IDLE.
REQ-034 Push 0x01..0x09 with FIFO_DEPTH=8 and the transmitter stalled busy -> wr_ready low after 8 accepted (one popped into LOAD allows the 9th), bytes transmitted in order.
REQ-035 Nine rx_done pulses carrying 0x10..0x18 with rd_ready=0 -> 0x10..0x17 stored, rx_overflow=1; clr_err -> flag 0.
REQ-036 Pulse rx_done with rx_err=1 and data 0x55 -> rx_level unchanged, rx_frame_err=1.
REQ-037 RX FIFO full with rd_ready=1 in the same cycle as a capture of 0x3C -> rx_level stays 8, no overflow, 0x3C read last.
REQ-038 Assert rst during WAIT -> all outputs at reset values next edge, no further start, levels 0.
